iob_eth_mii_rx: RTL and testbench
=================================

IOB_ETH_MII_RX -- requirements
Module: iob_eth_mii_rx

Interface
REQ-001 SHALL have parameter BUF_AW, default 11: receive-buffer address width in bytes.
REQ-002 SHALL have port rx_clk_i  input  1: MII receive clock, the only clock.
REQ-003 SHALL have port rx_arst_i  input  1: reset, synchronous, active-high.
REQ-004 SHALL have port rx_dv_i  input  1: MII receive data valid.
REQ-005 SHALL have port rx_er_i  input  1: MII receive error.
REQ-006 SHALL have port rx_data_i  input  4: MII nibble, low nibble of each byte first.
REQ-007 SHALL have port addr_o  output  BUF_AW: buffer write address.
REQ-008 SHALL have port data_o  output  8: buffer write byte.
REQ-009 SHALL have port wr_o  output  1: buffer write strobe, one cycle per byte.
REQ-010 SHALL have port nbytes_o  output  BUF_AW: bytes stored for the last frame, FCS included.
REQ-011 SHALL have port received_o  output  1: frame complete, waiting for acknowledge.
REQ-012 SHALL have port rcv_ack_i  input  1: consumer acknowledge; releases the buffer.
REQ-013 SHALL have port crc_err_o  output  1: FCS check failed for the last frame.
REQ-014 SHALL have port frame_err_o  output  1: rx_er_i, odd nibble count or overflow in the last frame.
REQ-015 SHALL have port drop_o  output  1: one-cycle pulse when a frame is discarded because the buffer is held.

Function
REQ-016 SHALL implement the states IDLE, PREAMBLE, DATA, HOLD, DISCARD.
REQ-017 IDLE: on rx_dv_i=1 with rx_data_i=4'h5, SHALL go to PREAMBLE; any other nibble SHALL go to DISCARD.
REQ-018 PREAMBLE: nibble 4'h5 SHALL keep the state; 4'hD (SFD) SHALL go to DATA with addr_o=0; any other nibble SHALL go to DISCARD.
REQ-019 PREAMBLE: rx_dv_i=0 SHALL go to IDLE.
REQ-020 DATA: SHALL latch the first nibble as the low half and the second nibble as the high half.
REQ-021 DATA: SHALL assert wr_o for exactly one cycle, in the cycle after the high nibble is sampled, with data_o holding the assembled byte and addr_o the byte index.
REQ-022 DATA: addr_o SHALL increment by 1 after each write.
REQ-023 DATA: rx_dv_i falling SHALL go to HOLD, with nbytes_o = bytes written and received_o=1 from the next cycle.
REQ-024 Odd nibble count at rx_dv_i fall: the dribble nibble SHALL be discarded and frame_err_o SHALL be set to 1.
REQ-025 rx_er_i=1 at any cycle in DATA SHALL set frame_err_o=1; reception SHALL continue.
REQ-026 Overflow: a byte at index 2^BUF_AW-1 SHALL be written; further bytes SHALL NOT be written, addr_o SHALL saturate, frame_err_o SHALL be set to 1, and nbytes_o SHALL equal 2^BUF_AW-1.
REQ-027 HOLD: rcv_ack_i=1 SHALL clear received_o next cycle and go to IDLE (or to DISCARD if rx_dv_i=1 in that cycle).
REQ-028 HOLD: nbytes_o, crc_err_o and frame_err_o SHALL be stable until the acknowledge.
REQ-029 HOLD: rx_dv_i rising SHALL pulse drop_o once per frame and SHALL NOT cause any writes.
REQ-030 DISCARD: SHALL stay until rx_dv_i=0, then go to IDLE, with no writes.
REQ-031 Simultaneous rcv_ack_i and rx_dv_i rise: the acknowledge SHALL take priority and the frame SHALL be discarded without a drop_o pulse.
REQ-032 Entering DATA SHALL clear crc_err_o and frame_err_o.

Reset
REQ-033 On rx_arst_i=1 at a rising edge of rx_clk_i, the block SHALL go to IDLE with addr_o=0, data_o=0, wr_o=0, nbytes_o=0, received_o=0, crc_err_o=0, frame_err_o=0 and drop_o=0.
REQ-034 Reset during DATA SHALL abandon the frame.
REQ-035 After reset release, the block SHALL NOT resynchronise onto a frame already in progress; it SHALL go to DISCARD until rx_dv_i=0.

Configuration
REQ-036 Macro IOB_ETH_RX_CRC_EN defined: every stored byte SHALL feed an iob_eth_crc instance, reinitialised on SFD.
REQ-037 With IOB_ETH_RX_CRC_EN defined: at entry to HOLD, crc_err_o SHALL be 1 iff the CRC residue differs from IOB_ETH_CRC_RESIDUE.
REQ-038 Macro IOB_ETH_RX_CRC_EN undefined: no CRC logic SHALL be present and crc_err_o SHALL be constant 0.

Structure
REQ-039 The shared package/header iob_eth_conf.vh SHALL hold the state encodings, IOB_ETH_PREAMBLE_NIBBLE (4'h5), IOB_ETH_SFD_NIBBLE (4'hD) and IOB_ETH_CRC_RESIDUE (32'hC704DD7B).
REQ-040 The single sub-module SHALL be the existing iob_eth_crc, instantiated only under IOB_ETH_RX_CRC_EN.

Verification
REQ-041 15x4'h5, 4'hD, then a 64-byte frame with valid FCS -> 64 wr_o pulses, addr 0..63, received_o=1, nbytes_o=64, crc_err_o=0, frame_err_o=0.
REQ-042 Same frame with byte 10 bit-flipped -> crc_err_o=1 with macro defined, crc_err_o=0 with it undefined; nbytes_o=64.
REQ-043 Frame ending with an extra nibble (129 nibbles) -> nbytes_o=64, frame_err_o=1.
REQ-044 Second frame while received_o=1 -> one drop_o pulse, zero writes, first-frame nbytes_o retained; rcv_ack_i then third frame -> normal reception.
REQ-045 BUF_AW=6 and a 100-byte frame -> writes at addresses 0..63 only, nbytes_o=63, frame_err_o=1.
REQ-046 rx_arst_i pulsed at byte 20 of a frame -> outputs at reset values, no further wr_o until the next frame, which is received correctly.

Source files
------------

// File: rtl/iob_eth_mii_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iob_eth_mii_rx_pkg
//  Description : Shared state encodings, MII framing nibbles and CRC-32 step
//                function for the MII receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package iob_eth_mii_rx_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        DATA     = 3'd2,
        HOLD     = 3'd3,
        DISCARD  = 3'd4
    } state_t;

    localparam logic [3:0]  IOB_ETH_PREAMBLE_NIBBLE = 4'h5;
    localparam logic [3:0]  IOB_ETH_SFD_NIBBLE      = 4'hD;
    localparam logic [31:0] IOB_ETH_CRC_RESIDUE     = 32'hC704DD7B;
    localparam logic [31:0] IOB_ETH_CRC_POLY        = 32'h04C11DB7;

    // MSB-first register, data bits consumed LSB first as they go on the wire.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ data[i])
                c = {c[30:0], 1'b0} ^ IOB_ETH_CRC_POLY;
            else
                c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_eth_crc.sv
`default_nettype none
// ============================================================================
//  Module      : iob_eth_crc
//  Description : Byte-wide Ethernet CRC-32 accumulator; present only when
//                IOB_ETH_RX_CRC_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifdef IOB_ETH_RX_CRC_EN
module iob_eth_crc
    import iob_eth_mii_rx_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] r_crc;

    always_ff @(posedge clk_i) begin
        if (rst_i || init_i)
            r_crc <= 32'hFFFFFFFF;
        else if (en_i)
            r_crc <= crc32_byte(r_crc, data_i);
    end

    assign crc_o = r_crc;

endmodule
`endif
`default_nettype wire

// File: rtl/iob_eth_mii_rx.sv
`default_nettype none
// ============================================================================
//  Module      : iob_eth_mii_rx
//  Description : MII receiver writing frame bytes into a single buffer held
//                until acknowledged. Define IOB_ETH_RX_CRC_EN for FCS check.
//  Revision    : 1.0 - initial release
// ============================================================================
module iob_eth_mii_rx
    import iob_eth_mii_rx_pkg::*;
#(
    parameter int BUF_AW = 11
) (
    input  logic              rx_clk_i,
    input  logic              rx_arst_i,
    input  logic              rx_dv_i,
    input  logic              rx_er_i,
    input  logic [3:0]        rx_data_i,
    output logic [BUF_AW-1:0] addr_o,
    output logic [7:0]        data_o,
    output logic              wr_o,
    output logic [BUF_AW-1:0] nbytes_o,
    output logic              received_o,
    input  logic              rcv_ack_i,
    output logic              crc_err_o,
    output logic              frame_err_o,
    output logic              drop_o
);

    localparam logic [BUF_AW-1:0] c_addr_max = '1;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_sfd;
    logic              w_drop;
    logic              w_byte_done;
    logic              w_store;
    logic              w_end;

    logic              r_dv_q;
    logic              r_phase;
    logic [3:0]        r_low;
    logic [BUF_AW-1:0] r_cnt;
    logic              r_full;
    logic [BUF_AW-1:0] r_addr;
    logic [7:0]        r_data;
    logic              r_wr;
    logic [BUF_AW-1:0] r_nbytes;
    logic              r_received;
    logic              r_frame_err;
    logic              r_drop;

    always_ff @(posedge rx_clk_i) begin
        if (rx_arst_i)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_sfd        = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            IDLE: begin
                // r_dv_q high here only right after reset: a frame is already running.
                if (rx_dv_i)
                    w_next_state = (!r_dv_q && rx_data_i == IOB_ETH_PREAMBLE_NIBBLE)
                                   ? PREAMBLE : DISCARD;
            end
            PREAMBLE: begin
                if (!rx_dv_i)
                    w_next_state = IDLE;
                else if (rx_data_i == IOB_ETH_SFD_NIBBLE) begin
                    w_next_state = DATA;
                    w_sfd        = 1'b1;
                end else if (rx_data_i != IOB_ETH_PREAMBLE_NIBBLE)
                    w_next_state = DISCARD;
            end
            DATA: begin
                if (!rx_dv_i)
                    w_next_state = HOLD;
            end
            HOLD: begin
                if (rcv_ack_i)
                    w_next_state = rx_dv_i ? DISCARD : IDLE;
                else if (rx_dv_i && !r_dv_q)
                    w_drop = 1'b1;
            end
            DISCARD: begin
                if (!rx_dv_i)
                    w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_byte_done = (r_state == DATA) && rx_dv_i && r_phase;
    assign w_store     = w_byte_done && !r_full;
    assign w_end       = (r_state == DATA) && !rx_dv_i;

    always_ff @(posedge rx_clk_i) begin
        if (rx_arst_i) begin
            r_dv_q      <= 1'b1;
            r_phase     <= 1'b0;
            r_low       <= 4'h0;
            r_cnt       <= '0;
            r_full      <= 1'b0;
            r_addr      <= '0;
            r_data      <= 8'h00;
            r_wr        <= 1'b0;
            r_nbytes    <= '0;
            r_received  <= 1'b0;
            r_frame_err <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_dv_q <= rx_dv_i;
            r_wr   <= 1'b0;
            r_drop <= w_drop;
            if (w_sfd) begin
                r_addr      <= '0;
                r_cnt       <= '0;
                r_full      <= 1'b0;
                r_phase     <= 1'b0;
                r_frame_err <= 1'b0;
            end
            if (r_state == DATA) begin
                if (rx_er_i)
                    r_frame_err <= 1'b1;
                if (rx_dv_i && !r_phase) begin
                    r_low   <= rx_data_i;
                    r_phase <= 1'b1;
                end
                if (w_byte_done) begin
                    r_phase <= 1'b0;
                    if (r_full)
                        r_frame_err <= 1'b1;
                end
                // r_cnt saturates at the last address; r_full blocks further writes.
                if (w_store) begin
                    r_wr   <= 1'b1;
                    r_data <= {rx_data_i, r_low};
                    r_addr <= r_cnt;
                    if (r_cnt == c_addr_max)
                        r_full <= 1'b1;
                    else
                        r_cnt <= r_cnt + 1'b1;
                end
                if (w_end) begin
                    r_nbytes   <= r_cnt;
                    r_received <= 1'b1;
                    if (r_phase)
                        r_frame_err <= 1'b1;
                end
            end
            if (r_state == HOLD && rcv_ack_i)
                r_received <= 1'b0;
        end
    end

`ifdef IOB_ETH_RX_CRC_EN
    logic [31:0] w_crc;
    logic        r_crc_err;

    iob_eth_crc u_crc (
        .clk_i  (rx_clk_i),
        .rst_i  (rx_arst_i),
        .init_i (w_sfd),
        .en_i   (w_store),
        .data_i ({rx_data_i, r_low}),
        .crc_o  (w_crc)
    );

    always_ff @(posedge rx_clk_i) begin
        if (rx_arst_i || w_sfd)
            r_crc_err <= 1'b0;
        else if (w_end)
            r_crc_err <= (w_crc != IOB_ETH_CRC_RESIDUE);
    end

    assign crc_err_o = r_crc_err;
`else
    assign crc_err_o = 1'b0;
`endif

    assign addr_o      = r_addr;
    assign data_o      = r_data;
    assign wr_o        = r_wr;
    assign nbytes_o    = r_nbytes;
    assign received_o  = r_received;
    assign frame_err_o = r_frame_err;
    assign drop_o      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_iob_eth_mii_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iob_eth_mii_rx
//  Description : Self-checking bench for iob_eth_mii_rx (default and 6-bit
//                buffer instances); write scoreboard fed by the frame driver.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_eth_mii_rx;

`ifdef IOB_ETH_RX_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    typedef struct packed {
        logic [10:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dv_a = 1'b0, dv_b = 1'b0, er = 1'b0, ack_a = 1'b0, ack_b = 1'b0;
    logic [3:0]  nib = 4'h0;

    logic [10:0] addr_a, nbytes_a;
    logic [7:0]  data_a, data_b;
    logic        wr_a, rcv_a, crc_a, ferr_a, drop_a;
    logic [5:0]  addr_b, nbytes_b;
    logic        wr_b, rcv_b, crc_b, ferr_b, drop_b;

    int          n_run = 0, n_fail = 0, n_wr = 0, n_drop = 0;
    wr_t         exp_q[$];
    logic [7:0]  tx[$];

    always #5 clk = ~clk;

    iob_eth_mii_rx #(.BUF_AW(11)) dut_a (
        .rx_clk_i(clk), .rx_arst_i(rst), .rx_dv_i(dv_a), .rx_er_i(er), .rx_data_i(nib),
        .addr_o(addr_a), .data_o(data_a), .wr_o(wr_a), .nbytes_o(nbytes_a),
        .received_o(rcv_a), .rcv_ack_i(ack_a), .crc_err_o(crc_a),
        .frame_err_o(ferr_a), .drop_o(drop_a)
    );

    iob_eth_mii_rx #(.BUF_AW(6)) dut_b (
        .rx_clk_i(clk), .rx_arst_i(rst), .rx_dv_i(dv_b), .rx_er_i(er), .rx_data_i(nib),
        .addr_o(addr_b), .data_o(data_b), .wr_o(wr_b), .nbytes_o(nbytes_b),
        .received_o(rcv_b), .rcv_ack_i(ack_b), .crc_err_o(crc_b),
        .frame_err_o(ferr_b), .drop_o(drop_b)
    );

    // Payload of n-4 random bytes followed by a correct FCS (reflected CRC-32).
    task automatic build(input int n, input int flip);
        logic [31:0] c;
        tx.delete();
        for (int i = 0; i < n - 4; i++) tx.push_back(8'($urandom_range(0, 255)));
        c = 32'hFFFFFFFF;
        foreach (tx[i]) begin
            c = c ^ {24'h0, tx[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) tx.push_back(c[8*k +: 8]);
        if (flip >= 0) tx[flip] = tx[flip] ^ 8'h01;
    endtask

    task automatic drive(input bit b, input logic v, input logic [3:0] n);
        if (b) dv_b = v; else dv_a = v;
        nib = n;
    endtask

    // One cycle: sample outputs at the falling edge and retire scoreboard writes.
    task automatic step(input bit b);
        wr_t        e;
        logic [10:0] a;
        logic [7:0]  d;
        @(negedge clk);
        a = b ? {5'd0, addr_b} : addr_a;
        d = b ? data_b : data_a;
        if (b ? drop_b : drop_a) n_drop++;
        if (b ? wr_b : wr_a) begin
            n_wr++;
            n_run++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %02h, expected no write", a, d);
            end else begin
                e = exp_q.pop_front();
                if (a !== e.addr || d !== e.data) begin
                    n_fail++;
                    $display("FAIL write: got addr %0d data %02h, expected addr %0d data %02h",
                             a, d, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic send_frame(input bit b, input bit store, input bit dribble, input int er_nib);
        wr_t e;
        int  max_idx;
        max_idx = b ? 63 : 2047;
        for (int i = 0; i < 16; i++) begin
            step(b);
            drive(b, 1'b1, (i == 15) ? 4'hD : 4'h5);
        end
        for (int i = 0; i < tx.size(); i++) begin
            if (store && i <= max_idx) begin
                e.addr = 11'(i);
                e.data = tx[i];
                exp_q.push_back(e);
            end
            step(b); drive(b, 1'b1, tx[i][3:0]); er = (er_nib == 2*i);
            step(b); drive(b, 1'b1, tx[i][7:4]); er = (er_nib == 2*i + 1);
        end
        if (dribble) begin
            step(b); drive(b, 1'b1, 4'hA); er = 1'b0;
        end
        step(b); drive(b, 1'b0, 4'h0); er = 1'b0;
        repeat (4) step(b);
    endtask

    task automatic ack(input bit b);
        step(b);
        if (b) ack_b = 1'b1; else ack_a = 1'b1;
        step(b);
        ack_a = 1'b0;
        ack_b = 1'b0;
    endtask

    task automatic check_hold(input string name, input int nb, input bit crc, input bit ferr);
        n_run++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL %s_pending: got %0d writes missing, expected 0", name, exp_q.size());
        end
        n_run++;
        if ({rcv_a, nbytes_a, crc_a, ferr_a} !== {1'b1, 11'(nb), crc, ferr}) begin
            n_fail++;
            $display("FAIL %s_status: got rcv %b nbytes %0d crc %b ferr %b, expected 1 %0d %b %b",
                     name, rcv_a, nbytes_a, crc_a, ferr_a, nb, crc, ferr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step(0);
        n_run++;
        if ({addr_a, data_a, wr_a, nbytes_a, rcv_a, crc_a, ferr_a, drop_a} !== '0) begin
            n_fail++; $display("FAIL reset_a: got outputs nonzero (addr %0d nbytes %0d), expected 0",
                               addr_a, nbytes_a);
        end
        n_run++;
        if ({addr_b, data_b, wr_b, nbytes_b, rcv_b, crc_b, ferr_b, drop_b} !== '0) begin
            n_fail++; $display("FAIL reset_b: got outputs nonzero (addr %0d nbytes %0d), expected 0",
                               addr_b, nbytes_b);
        end
        rst = 1'b0;
        repeat (3) step(0);
    endtask

    task automatic test_good_frame();
        int w0;
        w0 = n_wr;
        build(64, -1);
        send_frame(0, 1'b1, 1'b0, -1);
        n_run++;
        if (n_wr - w0 != 64) begin
            n_fail++; $display("FAIL good_wr_count: got %0d, expected 64", n_wr - w0);
        end
        check_hold("good", 64, 1'b0, 1'b0);
        ack(0);
        n_run++;
        if (rcv_a !== 1'b0) begin
            n_fail++; $display("FAIL good_ack: got received %b, expected 0", rcv_a);
        end
    endtask

    task automatic test_bad_crc();
        build(64, 10);
        send_frame(0, 1'b1, 1'b0, -1);
        check_hold("bad_crc", 64, CRC_ON, 1'b0);
        ack(0);
    endtask

    task automatic test_dribble();
        build(64, -1);
        send_frame(0, 1'b1, 1'b1, -1);
        check_hold("dribble", 64, 1'b0, 1'b1);
        ack(0);
    endtask

    task automatic test_rx_er();
        build(64, -1);
        send_frame(0, 1'b1, 1'b0, 41);
        check_hold("rx_er", 64, 1'b0, 1'b1);
        ack(0);
    endtask

    task automatic test_drop();
        int w0, d0;
        build(64, -1);
        send_frame(0, 1'b1, 1'b0, -1);
        w0 = n_wr; d0 = n_drop;
        build(40, -1);
        send_frame(0, 1'b0, 1'b0, -1);
        n_run++;
        if (n_drop - d0 != 1 || n_wr != w0) begin
            n_fail++; $display("FAIL drop: got %0d drops %0d writes, expected 1 drop 0 writes",
                               n_drop - d0, n_wr - w0);
        end
        check_hold("drop_retain", 64, 1'b0, 1'b0);
        ack(0);
        build(32, -1);
        send_frame(0, 1'b1, 1'b0, -1);
        check_hold("after_drop", 32, 1'b0, 1'b0);
        ack(0);
    endtask

    task automatic test_overflow();
        build(100, -1);
        send_frame(1, 1'b1, 1'b0, -1);
        n_run++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL ovf_pending: got %0d writes missing, expected 0", exp_q.size());
        end
        n_run++;
        if ({rcv_b, nbytes_b, ferr_b} !== {1'b1, 6'd63, 1'b1}) begin
            n_fail++; $display("FAIL ovf_status: got rcv %b nbytes %0d ferr %b, expected 1 63 1",
                               rcv_b, nbytes_b, ferr_b);
        end
        ack(1);
    endtask

    task automatic test_reset_mid();
        wr_t e;
        int  w0;
        build(64, -1);
        for (int i = 0; i < 16; i++) begin
            step(0); drive(0, 1'b1, (i == 15) ? 4'hD : 4'h5);
        end
        for (int i = 0; i < 20; i++) begin
            e.addr = 11'(i); e.data = tx[i]; exp_q.push_back(e);
            step(0); drive(0, 1'b1, tx[i][3:0]);
            step(0); drive(0, 1'b1, tx[i][7:4]);
        end
        step(0);
        rst = 1'b1; drive(0, 1'b1, tx[20][3:0]);
        step(0);
        rst = 1'b0;
        n_run++;
        if ({addr_a, data_a, wr_a, nbytes_a, rcv_a, crc_a, ferr_a, drop_a} !== '0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got addr %0d data %02h pend %0d, expected 0 00 0",
                               addr_a, data_a, exp_q.size());
        end
        w0 = n_wr;
        for (int i = 20; i < 64; i++) begin
            step(0); drive(0, 1'b1, tx[i][7:4]);
            step(0); drive(0, 1'b1, (i < 63) ? tx[i+1][3:0] : 4'h5);
        end
        step(0); drive(0, 1'b0, 4'h0);
        repeat (4) step(0);
        n_run++;
        if (n_wr != w0 || rcv_a !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_resync: got %0d writes received %b, expected 0 0",
                               n_wr - w0, rcv_a);
        end
        build(48, -1);
        send_frame(0, 1'b1, 1'b0, -1);
        check_hold("after_rst", 48, 1'b0, 1'b0);
        ack(0);
    endtask

    task automatic test_ack_with_rise();
        int w0, d0;
        build(48, -1);
        send_frame(0, 1'b1, 1'b0, -1);
        w0 = n_wr; d0 = n_drop;
        step(0);
        ack_a = 1'b1; drive(0, 1'b1, 4'h5);
        step(0);
        ack_a = 1'b0;
        n_run++;
        if (rcv_a !== 1'b0) begin
            n_fail++; $display("FAIL ack_rise_rcv: got received %b, expected 0", rcv_a);
        end
        for (int i = 0; i < 15; i++) begin
            step(0); drive(0, 1'b1, (i == 14) ? 4'hD : 4'h5);
        end
        for (int i = 0; i < 40; i++) begin
            step(0); drive(0, 1'b1, tx[i][3:0]);
            step(0); drive(0, 1'b1, tx[i][7:4]);
        end
        step(0); drive(0, 1'b0, 4'h0);
        repeat (4) step(0);
        n_run++;
        if (n_wr != w0 || n_drop != d0 || rcv_a !== 1'b0) begin
            n_fail++; $display("FAIL ack_rise: got %0d writes %0d drops received %b, expected 0 0 0",
                               n_wr - w0, n_drop - d0, rcv_a);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_dribble();
        test_rx_er();
        test_drop();
        test_overflow();
        test_reset_mid();
        test_ack_with_rise();
        test_good_frame();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
